// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU function issuer.
package alu_pkg;

    // Unit codes placed in ALU_FUNC[3:2]; the inverse of the downstream enable decode.
    localparam logic [1:0] UnitArith = 2'b00;
    localparam logic [1:0] UnitLogic = 2'b01;
    localparam logic [1:0] UnitCmp   = 2'b10;
    localparam logic [1:0] UnitShift = 2'b11;

    // Bit positions of each unit inside REQ and GNT.
    localparam logic [1:0] IdxArith = 2'd3;
    localparam logic [1:0] IdxLogic = 2'd2;
    localparam logic [1:0] IdxCmp   = 2'd1;
    localparam logic [1:0] IdxShift = 2'd0;

    // Pointer value after reset: the search starts at the Arith requester.
    localparam logic [1:0] PtrReset = IdxArith;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StAck   = 2'd2
    } state_e;

    // Map a REQ/GNT bit index to the unit code carried in ALU_FUNC.
    function automatic logic [1:0] unit_code(input logic [1:0] idx);
        logic [1:0] code;
        code = UnitArith;
        unique case (idx)
            IdxArith: code = UnitArith;
            IdxLogic: code = UnitLogic;
            IdxCmp:   code = UnitCmp;
            IdxShift: code = UnitShift;
            default:  code = UnitArith;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin selector: the search starts at ptr_i and walks downward,
// wrapping from bit 0 to bit 3. Purely combinational; the caller owns the pointer.
module rr_arb4
    import alu_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] win_oh_o,
    output logic [1:0] win_idx_o,
    output logic       any_o
);

    // Pick the first set request encountered in descending order from the pointer.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        found     = 1'b0;
        cand      = ptr_i;
        win_oh_o  = 4'b0000;
        win_idx_o = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_i - 2'(k);
            if (!found && req_i[cand]) begin
                found           = 1'b1;
                win_idx_o       = cand;
                win_oh_o[cand]  = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/alu_func_issuer.sv
// Arbitrates four ALU unit requesters, presents the winning encoded function to
// the ALU with a valid/ready handshake, then pulses the winner's grant.
module alu_func_issuer
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       REQ,
    input  logic [1:0]       ARITH_OP,
    input  logic [1:0]       LOGIC_OP,
    input  logic [1:0]       CMP_OP,
    input  logic [1:0]       SHIFT_OP,
    input  logic             FUNC_READY,
    output logic [3:0]       ALU_FUNC,
    output logic             FUNC_VALID,
    output logic [3:0]       GNT,
    output logic [CNT_W-1:0] ISSUE_CNT
);

    state_e           state_q, state_d;
    logic [3:0]       func_q, func_d;
    logic             valid_q, valid_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    // Winner of the operation in flight, kept for the grant pulse and pointer move.
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       oh_q, oh_d;

    logic [3:0]       arb_oh;
    logic [1:0]       arb_idx;
    logic             arb_any;
    logic [1:0]       sub_op;

    rr_arb4 u_arb (
        .req_i     (REQ),
        .ptr_i     (ptr_q),
        .win_oh_o  (arb_oh),
        .win_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    // Select the sub-operation belonging to the current arbitration winner.
    always_comb begin
        sub_op = 2'b00;
        unique case (arb_idx)
            IdxArith: sub_op = ARITH_OP;
            IdxLogic: sub_op = LOGIC_OP;
            IdxCmp:   sub_op = CMP_OP;
            IdxShift: sub_op = SHIFT_OP;
            default:  sub_op = 2'b00;
        endcase
    end

    // Next-state logic for the IDLE -> ISSUE -> ACK cycle.
    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        valid_d = valid_q;
        gnt_d   = 4'b0000;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (arb_any) begin
                    // Sub-ops are captured here only; later input changes are ignored.
                    func_d  = {unit_code(arb_idx), sub_op};
                    idx_d   = arb_idx;
                    oh_d    = arb_oh;
                    valid_d = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Operation is committed: dropped requests no longer matter.
                if (FUNC_READY) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    gnt_d   = oh_q;
                    ptr_d   = idx_q - 2'd1;
                    state_d = StAck;
                end
            end
            StAck: begin
                // Grant is visible for this cycle only; no arbitration here.
                state_d = StIdle;
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= StIdle;
            func_q  <= 4'b0000;
            valid_q <= 1'b0;
            gnt_q   <= 4'b0000;
            cnt_q   <= '0;
            ptr_q   <= PtrReset;
            idx_q   <= 2'd0;
            oh_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
        end
    end

    assign ALU_FUNC   = func_q;
    assign FUNC_VALID = valid_q;
    assign GNT        = gnt_q;
    assign ISSUE_CNT  = cnt_q;

endmodule

// File: tb/tb_alu_func_issuer.sv
// Bench for alu_func_issuer: directed vector table, hand-written corner
// sequences, and randomized traffic against a transaction-level model.
module tb_alu_func_issuer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] aop, lop, cop, sop;
    logic       ready;
    logic [3:0] alu_func;
    logic       func_valid;
    logic [3:0] gnt;
    logic [7:0] issue_cnt;

    int n_cmp = 0;
    int n_err = 0;

    alu_func_issuer #(.CNT_W(8)) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .REQ        (req),
        .ARITH_OP   (aop),
        .LOGIC_OP   (lop),
        .CMP_OP     (cop),
        .SHIFT_OP   (sop),
        .FUNC_READY (ready),
        .ALU_FUNC   (alu_func),
        .FUNC_VALID (func_valid),
        .GNT        (gnt),
        .ISSUE_CNT  (issue_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: one pending operation, one grant-pulse cycle, RR pointer, counter.
    bit         m_pending;
    bit         m_pulse;
    int         m_idx;
    int         m_ptr;
    int         m_cnt;
    logic [3:0] m_func;

    function automatic void model_edge();
        logic [1:0] ops [4];
        ops[3] = aop; ops[2] = lop; ops[1] = cop; ops[0] = sop;
        if (rst_n !== 1'b1) begin
            m_pending = 0; m_pulse = 0; m_idx = 0; m_ptr = 3; m_cnt = 0; m_func = 4'b0000;
        end else if (m_pulse) begin
            m_pulse = 0;
        end else if (m_pending) begin
            if (ready) begin
                m_pending = 0;
                m_pulse   = 1;
                m_cnt     = (m_cnt + 1) % 256;
                m_ptr     = (m_idx + 3) % 4;
            end
        end else if (req != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr - k + 4) % 4;
                if (!m_pending && req[i]) begin
                    m_pending = 1;
                    m_idx     = i;
                    m_func    = {2'(3 - i), ops[i]};
                end
            end
        end
    endfunction

    function automatic logic [3:0] model_gnt();
        return m_pulse ? (4'b0001 << m_idx) : 4'b0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One clock: DUT and model both see the inputs present at the rising edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_func"},  32'(alu_func),   32'(m_func));
        chk({tag, "_valid"}, 32'(func_valid), 32'(m_pending));
        chk({tag, "_gnt"},   32'(gnt),        32'(model_gnt()));
        chk({tag, "_cnt"},   32'(issue_cnt),  32'(m_cnt));
    endtask

    task automatic check_out(input string tag, input logic [3:0] f, input logic v,
                             input logic [3:0] g, input logic [7:0] c);
        chk({tag, "_func"},  32'(alu_func),   32'(f));
        chk({tag, "_valid"}, 32'(func_valid), 32'(v));
        chk({tag, "_gnt"},   32'(gnt),        32'(g));
        chk({tag, "_cnt"},   32'(issue_cnt),  32'(c));
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [1:0] aop, lop, cop, sop;
        logic       ready;
        logic [3:0] e_func;
        logic       e_valid;
        logic [3:0] e_gnt;
        logic [7:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [1:0] a,
                                input logic [1:0] l, input logic [1:0] c, input logic [1:0] s,
                                input logic rd, input logic [3:0] ef, input logic ev,
                                input logic [3:0] eg, input logic [7:0] ec);
        vec_t v;
        v.rst = r; v.req = rq; v.aop = a; v.lop = l; v.cop = c; v.sop = s; v.ready = rd;
        v.e_func = ef; v.e_valid = ev; v.e_gnt = eg; v.e_cnt = ec;
        return v;
    endfunction

    vec_t vecs [20];

    initial begin
        rst_n = 1'b0; req = 4'b0000; aop = 0; lop = 0; cop = 0; sop = 0; ready = 1'b0;
        m_pending = 0; m_pulse = 0; m_idx = 0; m_ptr = 3; m_cnt = 0; m_func = 4'b0000;

        // Reset with all requesters high, single CMP op, then fairness sweep from reset.
        vecs[0]  = mk(0, 4'b1111, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0);
        vecs[1]  = mk(0, 4'b1111, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0);
        vecs[2]  = mk(1, 4'b0010, 0, 0, 1, 0, 1, 4'b1001, 1, 4'b0000, 0);
        vecs[3]  = mk(1, 4'b0010, 0, 0, 1, 0, 1, 4'b1001, 0, 4'b0010, 1);
        vecs[4]  = mk(1, 4'b0000, 0, 0, 1, 0, 1, 4'b1001, 0, 4'b0000, 1);
        vecs[5]  = mk(0, 4'b1111, 1, 2, 3, 0, 1, 4'b0000, 0, 4'b0000, 0);
        vecs[6]  = mk(1, 4'b1111, 1, 2, 3, 0, 1, 4'b0001, 1, 4'b0000, 0);
        vecs[7]  = mk(1, 4'b1111, 1, 2, 3, 0, 1, 4'b0001, 0, 4'b1000, 1);
        vecs[8]  = mk(1, 4'b1111, 1, 2, 3, 0, 1, 4'b0001, 0, 4'b0000, 1);
        vecs[9]  = mk(1, 4'b1111, 1, 2, 3, 0, 1, 4'b0110, 1, 4'b0000, 1);
        vecs[10] = mk(1, 4'b1111, 1, 2, 3, 0, 1, 4'b0110, 0, 4'b0100, 2);
        vecs[11] = mk(1, 4'b1111, 1, 2, 3, 0, 1, 4'b0110, 0, 4'b0000, 2);
        vecs[12] = mk(1, 4'b1111, 1, 2, 3, 0, 1, 4'b1011, 1, 4'b0000, 2);
        vecs[13] = mk(1, 4'b1111, 1, 2, 3, 0, 1, 4'b1011, 0, 4'b0010, 3);
        vecs[14] = mk(1, 4'b1111, 1, 2, 3, 0, 1, 4'b1011, 0, 4'b0000, 3);
        vecs[15] = mk(1, 4'b1111, 1, 2, 3, 0, 1, 4'b1100, 1, 4'b0000, 3);
        vecs[16] = mk(1, 4'b1111, 1, 2, 3, 0, 1, 4'b1100, 0, 4'b0001, 4);
        vecs[17] = mk(1, 4'b1111, 1, 2, 3, 0, 1, 4'b1100, 0, 4'b0000, 4);
        vecs[18] = mk(1, 4'b1111, 1, 2, 3, 0, 1, 4'b0001, 1, 4'b0000, 4);
        vecs[19] = mk(1, 4'b1111, 1, 2, 3, 0, 1, 4'b0001, 0, 4'b1000, 5);

        for (int v = 0; v < 20; v++) begin
            rst_n = vecs[v].rst; req = vecs[v].req; ready = vecs[v].ready;
            aop = vecs[v].aop; lop = vecs[v].lop; cop = vecs[v].cop; sop = vecs[v].sop;
            step();
            check_out($sformatf("vec%0d", v), vecs[v].e_func, vecs[v].e_valid,
                      vecs[v].e_gnt, vecs[v].e_cnt);
        end

        // Backpressure: held op stays stable for 5 stalled cycles despite SHIFT_OP change.
        rst_n = 1'b0; req = 4'b0000; ready = 1'b0; step();
        rst_n = 1'b1; req = 4'b0001; sop = 2'b10; aop = 0; lop = 0; cop = 0;
        step();
        check_out("bp_issue", 4'b1110, 1'b1, 4'b0000, 8'd0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) sop = 2'b01;
            step();
            check_out($sformatf("bp_wait%0d", c), 4'b1110, 1'b1, 4'b0000, 8'd0);
        end
        ready = 1'b1;
        step();
        check_out("bp_ack", 4'b1110, 1'b0, 4'b0001, 8'd1);
        req = 4'b0000;
        step();
        check_out("bp_idle", 4'b1110, 1'b0, 4'b0000, 8'd1);

        // Reset while an operation waits for FUNC_READY: abandoned without grant or count.
        rst_n = 1'b0; step();
        rst_n = 1'b1; req = 4'b1000; aop = 2'b11; ready = 1'b0;
        step();
        check_out("rmid_issue", 4'b0011, 1'b1, 4'b0000, 8'd0);
        rst_n = 1'b0; ready = 1'b1;
        step();
        check_out("rmid_rst", 4'b0000, 1'b0, 4'b0000, 8'd0);
        rst_n = 1'b1; req = 4'b0000;
        step();
        check_out("rmid_after", 4'b0000, 1'b0, 4'b0000, 8'd0);

        // Counter wrap: 256 back-to-back handshakes bring ISSUE_CNT back to 0.
        rst_n = 1'b0; step();
        rst_n = 1'b1; req = 4'b1111; ready = 1'b1;
        for (int s = 0; s < 764; s++) step();
        chk("wrap_255", 32'(issue_cnt), 32'd255);
        for (int s = 0; s < 3; s++) step();
        chk("wrap_0", 32'(issue_cnt), 32'd0);
        chk("wrap_gnt", 32'(gnt != 4'b0000), 32'd1);

        // Randomized traffic: requesters hold until granted, occasionally retract.
        rst_n = 1'b0; req = 4'b0000; ready = 1'b0; step();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [3:0] g;
            g = model_gnt();
            for (int b = 0; b < 4; b++) begin
                if (g[b]) req[b] = 1'b0;
                else if (!req[b] && $urandom_range(0, 3) == 0) req[b] = 1'b1;
                else if (req[b] && $urandom_range(0, 31) == 0) req[b] = 1'b0;
            end
            aop   = 2'($urandom_range(0, 3));
            lop   = 2'($urandom_range(0, 3));
            cop   = 2'($urandom_range(0, 3));
            sop   = 2'($urandom_range(0, 3));
            ready = ($urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 99) != 0);
            step();
            check_model($sformatf("rnd%0d", cyc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_func_issuer.md
ALU_FUNC_ISSUER -- requirements
Module: alu_func_issuer

Interface
REQ-001 Parameter CNT_W, default 8, width of issued-operation counter ISSUE_CNT.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; synchronous, active-low.
REQ-004 REQ  input  4  unit request bits: [3]=Arith, [2]=Logic, [1]=CMP, [0]=SHIFT; a requester holds its bit high until granted.
REQ-005 ARITH_OP, LOGIC_OP, CMP_OP, SHIFT_OP  input  2 each  sub-operation for each unit, sampled at arbitration.
REQ-006 FUNC_READY  input  1  downstream ALU accepts ALU_FUNC this cycle.
REQ-007 ALU_FUNC  output  4  encoded function: [3:2] unit code, [1:0] sub-op.
REQ-008 FUNC_VALID  output  1  ALU_FUNC holds a pending operation.
REQ-009 GNT  output  4  one-cycle grant pulse, same bit order as REQ.
REQ-010 ISSUE_CNT  output  CNT_W  count of completed handshakes.

Function
REQ-011 Unit codes SHALL be Arith=2'b00, Logic=2'b01, CMP=2'b10, SHIFT=2'b11 (inverse of the ALU enable decode).
REQ-012 FSM states SHALL be IDLE, ISSUE, ACK.
REQ-013 IDLE: if any REQ bit set, SHALL arbitrate, register ALU_FUNC={code,sub-op} of winner, set FUNC_VALID, go ISSUE; else stay IDLE, FUNC_VALID=0.
REQ-014 Arbitration SHALL be round-robin: search starts at pointer PTR, proceeds descending bit index, wraps 0->3.
REQ-015 ISSUE: ALU_FUNC and FUNC_VALID SHALL hold stable until a cycle with FUNC_READY=1; on that edge go ACK, clear FUNC_VALID, increment ISSUE_CNT.
REQ-016 ACK: GNT SHALL be one-hot at the issued unit for exactly this cycle; PTR SHALL move to (granted index - 1) mod 4; next state IDLE.
REQ-017 The granted unit's REQ bit SHALL be ignored during ACK; no arbitration occurs in ACK.
REQ-018 Latency: REQ high at edge N in IDLE -> FUNC_VALID high after edge N; minimum throughput one operation per 3 cycles.
REQ-019 Requests dropped during ISSUE SHALL NOT retract the operation; it completes normally.
REQ-020 Sub-op inputs SHALL be sampled only in IDLE at arbitration; later changes do not affect ALU_FUNC.
REQ-021 ISSUE_CNT SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-022 GNT SHALL be 4'b0000 in IDLE and ISSUE.
REQ-023 FUNC_READY outside ISSUE SHALL be ignored.

Reset
REQ-024 With RST=0 at a rising edge: state=IDLE, ALU_FUNC=4'b0000, FUNC_VALID=0, GNT=4'b0000, ISSUE_CNT=0, PTR=3 (Arith).
REQ-025 Reset mid-operation (ISSUE or ACK) SHALL abandon the operation: no GNT pulse, no counter increment.
REQ-026 RST SHALL have no asynchronous effect between clock edges.

Structure
REQ-027 Package alu_pkg SHALL hold unit code constants, FSM state type, and REQ/GNT bit index constants.
REQ-028 Round-robin selection SHALL be a sub-module rr_arb4 (inputs REQ, PTR; outputs one-hot winner, winner index, any).
REQ-029 All outputs SHALL be registered.

Verification
REQ-030 Reset: RST=0 two cycles with REQ=4'b1111 -> ALU_FUNC=0, FUNC_VALID=0, GNT=0, ISSUE_CNT=0.
REQ-031 Single: REQ=4'b0010, CMP_OP=2'b01, FUNC_READY=1 -> ALU_FUNC=4'b1001 one cycle later, GNT=4'b0010 pulse next, ISSUE_CNT=1.
REQ-032 Fairness: REQ=4'b1111 held, FUNC_READY=1 -> grant order Arith, Logic, CMP, SHIFT, Arith; ALU_FUNC[3:2]=00,01,10,11,00.
REQ-033 Backpressure: REQ=4'b0001, SHIFT_OP=2'b10, FUNC_READY=0 for 5 cycles then 1 -> ALU_FUNC=4'b1110 stable all 5 cycles, one GNT pulse, ISSUE_CNT+1; SHIFT_OP changed mid-wait has no effect.
REQ-034 Reset mid-ISSUE: RST=0 while FUNC_VALID=1 -> next cycle all outputs at reset values, no GNT pulse, ISSUE_CNT unchanged at 0.
REQ-035 Wrap: 256 completed handshakes with CNT_W=8 -> ISSUE_CNT returns to 0.
